// File: rtl/obi_mgr_arbiter.sv
// Two-manager OBI arbiter: round-robin selection, request lock until grant,
// outstanding limit and in-order response routing. Optional macro: OBI_ARB_ID_CHECK_EN.
module obi_mgr_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter int DataWidth      = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   m_req_i,
  input  logic [1:0]                   m_we_i,
  input  logic [2*(DataWidth/8)-1:0]   m_be_i,
  input  logic [63:0]                  m_addr_i,
  input  logic [2*DataWidth-1:0]       m_wdata_i,
  output logic [1:0]                   m_gnt_o,
  output logic [1:0]                   m_rvalid_o,
  output logic [1:0]                   m_err_o,
  output logic [DataWidth-1:0]         m_rdata_o,
  output logic                         s_req_o,
  output logic                         s_we_o,
  output logic [(DataWidth/8)-1:0]     s_be_o,
  output logic [31:0]                  s_addr_o,
  output logic [DataWidth-1:0]         s_wdata_o,
  output logic                         s_aid_o,
  input  logic                         s_gnt_i,
  input  logic                         s_rvalid_i,
  input  logic                         s_err_i,
  input  logic [DataWidth-1:0]         s_rdata_i,
  input  logic                         s_rid_i,
  output logic                         proto_err_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int CntW    = $clog2(MaxOutstanding + 1);
  localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      ptr_q;
  logic                      sel_q;
  logic                      sel;
  logic                      req;
  logic                      hs;
  logic                      pop;
  logic                      head;
  logic                      rsp_bad;
  logic                      id_bad;
  logic                      can_issue;
  logic [CntW-1:0]           cnt_q;
  logic [PtrW-1:0]           rd_q, wr_q;
  logic [MaxOutstanding-1:0] fifo_q;
  logic                      proto_err_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A response arriving this cycle frees a slot, so the limit is relaxed in the same cycle.
  always_comb begin
    state_d   = state_q;
    sel       = 1'b0;
    req       = 1'b0;
    head      = fifo_q[rd_q];
    pop       = rst_ni & s_rvalid_i & (cnt_q != '0);
    rsp_bad   = rst_ni & s_rvalid_i & (cnt_q == '0);
    can_issue = (cnt_q < CntW'(MaxOutstanding)) | pop;
    if (!rst_ni) begin
      state_d = IDLE;
    end else if (state_q == HOLD) begin
      sel = sel_q;
      req = 1'b1;
    end else begin
      sel = (m_req_i == 2'b11) ? ptr_q : m_req_i[1];
      req = (|m_req_i) & can_issue;
    end
    hs = req & s_gnt_i;
    if (req && !s_gnt_i) begin
      state_d = HOLD;
    end else begin
      state_d = IDLE;
    end
  end

`ifdef OBI_ARB_ID_CHECK_EN
  assign id_bad = pop & (s_rid_i != head);
`else
  logic unused_rid;
  assign unused_rid = s_rid_i;
  assign id_bad     = 1'b0;
`endif

  assign s_req_o     = req;
  assign s_aid_o     = sel;
  assign s_we_o      = m_we_i[sel];
  assign s_be_o      = m_be_i[sel*BeWidth +: BeWidth];
  assign s_addr_o    = m_addr_i[sel*32 +: 32];
  assign s_wdata_o   = m_wdata_i[sel*DataWidth +: DataWidth];
  assign m_gnt_o     = {hs & sel, hs & ~sel};
  assign m_rvalid_o  = {pop & head, pop & ~head};
  assign m_err_o     = {pop & head & s_err_i, pop & ~head & s_err_i};
  assign m_rdata_o   = rst_ni ? s_rdata_i : '0;
  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      fifo_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel;
      if (hs) begin
        ptr_q        <= ~sel;
        fifo_q[wr_q] <= sel;
        wr_q         <= ptr_inc(wr_q);
      end
      if (pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      case ({hs, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (rsp_bad || id_bad) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_mgr_arbiter.sv
// Self-checking bench for obi_mgr_arbiter: expected grant owners are queued as
// transactions are granted and popped as responses come back.
module tb_obi_mgr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [7:0]  m_be;
  logic [63:0] m_addr, m_wdata;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_req, s_we, s_aid, s_gnt, s_rvalid, s_err, s_rid, proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_q[$];

`ifdef OBI_ARB_ID_CHECK_EN
  localparam logic ID_EXP = 1'b1;
`else
  localparam logic ID_EXP = 1'b0;
`endif

  obi_mgr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_err_o(m_err), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_aid_o(s_aid), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_err_i(s_err),
    .s_rdata_i(s_rdata), .s_rid_i(s_rid), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    m_req = 2'b00; m_we = 2'b10; m_be = 8'hF3;
    m_addr = {32'h2000_0020, 32'h1000_0010};
    m_wdata = {32'h5555_1111, 32'h4444_0000};
    s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = 32'h0; s_rid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    rsp_q.delete();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    tick(); tick(); settle();
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_s_req got %b want 0", s_req); end
    n_checks++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL rst_m_gnt got %b want 00", m_gnt); end
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_m_rvalid got %b want 00", m_rvalid); end
    n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m_rdata got %h want 0", m_rdata); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err got %b want 0", proto_err); end
    n_checks++; if (s_addr !== 32'h1000_0010) begin n_fail++; $display("FAIL rst_s_addr got %h want 10000010", s_addr); end
    n_checks++; if (s_aid !== 1'b0) begin n_fail++; $display("FAIL rst_s_aid got %b want 0", s_aid); end
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int id;
    logic [1:0] exp;
    do_reset();
    m_req = 2'b11; s_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = (i > 0); s_rdata = 32'hC0DE_0000 + 32'(i);
      settle();
      id = i % 2;
      exp = 2'b01 << id;
      n_checks++; if (m_gnt !== exp) begin n_fail++; $display("FAIL rr_gnt cycle %0d got %b want %b", i, m_gnt, exp); end
      n_checks++; if (s_aid !== 1'(id)) begin n_fail++; $display("FAIL rr_aid cycle %0d got %b want %0d", i, s_aid, id); end
      n_checks++; if (s_we !== m_we[id]) begin n_fail++; $display("FAIL rr_we cycle %0d got %b want %b", i, s_we, m_we[id]); end
      n_checks++; if (s_wdata !== m_wdata[id*32 +: 32]) begin n_fail++; $display("FAIL rr_wdata cycle %0d got %h", i, s_wdata); end
      if (i > 0) begin
        exp = 2'b01 << rsp_q.pop_front();
        n_checks++; if (m_rvalid !== exp) begin n_fail++; $display("FAIL rr_rvalid cycle %0d got %b want %b", i, m_rvalid, exp); end
      end
      rsp_q.push_back(id);
      tick();
    end
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
    settle();
    exp = 2'b01 << rsp_q.pop_front();
    n_checks++; if (m_rvalid !== exp) begin n_fail++; $display("FAIL rr_drain got %b want %b", m_rvalid, exp); end
    tick();
    s_rvalid = 1'b0;
  endtask

  task automatic test_hold();
    logic [1:0]  exp;
    logic [31:0] data;
    logic        err;
    do_reset();
    m_addr = {32'h1000_0004, 32'h0000_0100};
    m_req = 2'b10; s_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) m_req = 2'b11;
      if (c == 3) s_gnt = 1'b1;
      settle();
      exp = (c == 3) ? 2'b10 : 2'b00;
      n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL hold_req cycle %0d got %b want 1", c, s_req); end
      n_checks++; if (s_aid !== 1'b1) begin n_fail++; $display("FAIL hold_aid cycle %0d got %b want 1", c, s_aid); end
      n_checks++; if (s_addr !== 32'h1000_0004) begin n_fail++; $display("FAIL hold_addr cycle %0d got %h want 10000004", c, s_addr); end
      n_checks++; if (m_gnt !== exp) begin n_fail++; $display("FAIL hold_gnt cycle %0d got %b want %b", c, m_gnt, exp); end
      tick();
    end
    rsp_q.push_back(1);
    settle();
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL hold_next_gnt got %b want 01", m_gnt); end
    n_checks++; if (s_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL hold_next_addr got %h want 00000100", s_addr); end
    rsp_q.push_back(0);
    tick();
    m_req = 2'b00; s_gnt = 1'b0;
    for (int k = 0; k < 8 && rsp_q.size() > 0; k++) begin
      data = $urandom; err = 1'($urandom_range(0, 1));
      s_rvalid = 1'b1; s_rdata = data; s_err = err;
      settle();
      exp = 2'b01 << rsp_q.pop_front();
      n_checks++; if (m_rvalid !== exp) begin n_fail++; $display("FAIL hold_rsp_rvalid got %b want %b", m_rvalid, exp); end
      n_checks++; if (m_err !== (err ? exp : 2'b00)) begin n_fail++; $display("FAIL hold_rsp_err got %b want %b", m_err, err ? exp : 2'b00); end
      n_checks++; if (m_rdata !== data) begin n_fail++; $display("FAIL hold_rsp_rdata got %h want %h", m_rdata, data); end
      tick();
    end
    s_rvalid = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_outstanding();
    logic [1:0] exp;
    do_reset();
    m_req = 2'b01; s_gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL os_gnt cycle %0d got %b want 01", c, m_gnt); end
      rsp_q.push_back(0);
      tick();
    end
    settle();
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL os_limit_req got %b want 0", s_req); end
    n_checks++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL os_limit_gnt got %b want 00", m_gnt); end
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    settle();
    n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL os_reassert_req got %b want 1", s_req); end
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL os_reassert_gnt got %b want 01", m_gnt); end
    exp = 2'b01 << rsp_q.pop_front();
    n_checks++; if (m_rvalid !== exp) begin n_fail++; $display("FAIL os_rvalid got %b want %b", m_rvalid, exp); end
    rsp_q.push_back(0);
    tick();
    m_req = 2'b00; s_gnt = 1'b0;
    for (int k = 0; k < 8 && rsp_q.size() > 0; k++) begin
      settle();
      exp = 2'b01 << rsp_q.pop_front();
      n_checks++; if (m_rvalid !== exp) begin n_fail++; $display("FAIL os_drain got %b want %b", m_rvalid, exp); end
      tick();
    end
    s_rvalid = 1'b0;
    settle();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL os_proto_err got %b want 0", proto_err); end
  endtask

  task automatic test_response_routing();
    do_reset();
    m_req = 2'b01; s_gnt = 1'b1;
    settle();
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL route_gnt0 got %b want 01", m_gnt); end
    tick();
    m_req = 2'b10;
    settle();
    n_checks++; if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL route_gnt1 got %b want 10", m_gnt); end
    tick();
    m_req = 2'b00; s_gnt = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hAAAA_0000; s_err = 1'b0;
    settle();
    n_checks++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL route_rv0 got %b want 01", m_rvalid); end
    n_checks++; if (m_rdata !== 32'hAAAA_0000) begin n_fail++; $display("FAIL route_rd0 got %h want aaaa0000", m_rdata); end
    tick();
    s_rdata = 32'hBBBB_1111; s_err = 1'b1;
    settle();
    n_checks++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL route_rv1 got %b want 10", m_rvalid); end
    n_checks++; if (m_rdata !== 32'hBBBB_1111) begin n_fail++; $display("FAIL route_rd1 got %h want bbbb1111", m_rdata); end
    n_checks++; if (m_err !== 2'b10) begin n_fail++; $display("FAIL route_err1 got %b want 10", m_err); end
    tick();
    s_rvalid = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_proto_err();
    do_reset();
    settle();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_init got %b want 0", proto_err); end
    s_rvalid = 1'b1;
    settle();
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL perr_drop got %b want 00", m_rvalid); end
    tick();
    s_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky cycle %0d got %b want 1", c, proto_err); end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_cleared got %b want 0", proto_err); end
    m_req = 2'b01; s_gnt = 1'b1;
    tick(); tick();
    settle();
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL perr_count_zero got %b want 0", s_req); end
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s_rvalid = 1'b1;
    settle();
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL perr_stale_rsp got %b want 00", m_rvalid); end
    tick();
    s_rvalid = 1'b0;
    settle();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_stale_flag got %b want 1", proto_err); end
  endtask

  task automatic test_id_check();
    do_reset();
    m_req = 2'b01; s_gnt = 1'b1;
    tick();
    m_req = 2'b00; s_gnt = 1'b0;
    s_rvalid = 1'b1; s_rid = 1'b1;
    settle();
    n_checks++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL idchk_rvalid got %b want 01", m_rvalid); end
    tick();
    s_rvalid = 1'b0; s_rid = 1'b0;
    settle();
    n_checks++; if (proto_err !== ID_EXP) begin n_fail++; $display("FAIL idchk_proto_err got %b want %b", proto_err, ID_EXP); end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_hold();
    test_outstanding();
    test_response_routing();
    test_proto_err();
    test_id_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
